// File: rtl/camera_pkg.sv
// Shared types and constants for the camera capture path.
// Frame geometry defaults, the writer FSM state type and a saturating counter helper.
package camera_pkg;

    localparam int DEF_IMG_W    = 640;
    localparam int DEF_IMG_H    = 480;
    localparam int FRAME_PIXELS = DEF_IMG_W * DEF_IMG_H;

    typedef enum logic {
        SYNC    = 1'b0,
        CAPTURE = 1'b1
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/gray_frame_writer_if.sv
// Pixel stream in, frame-buffer write port and consumer handshake out.
// The slave side is the frame writer; the master side is the camera/consumer environment.
interface gray_frame_writer_if #(
    parameter int ADDR_W = 20
);
    logic [7:0]        gray;
    logic              pixel_valid;
    logic              frame_done;
    logic              frame_release;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              frame_ready;
    logic              rd_valid;
    logic              rd_bank;
    logic              frame_error;
    logic [7:0]        drop_count;

    modport slave (
        input  gray, pixel_valid, frame_done, frame_release,
        output wr_en, wr_addr, wr_data, frame_ready, rd_valid, rd_bank,
               frame_error, drop_count
    );

    modport master (
        output gray, pixel_valid, frame_done, frame_release,
        input  wr_en, wr_addr, wr_data, frame_ready, rd_valid, rd_bank,
               frame_error, drop_count
    );
endinterface

// File: rtl/frame_bank_ctrl.sv
// Ping-pong bank ownership: full flag, write/read bank selection and dropped-frame count.
// A release in the same cycle as a completed frame frees the bank before the frame is judged.
module frame_bank_ctrl
    import camera_pkg::*;
(
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       frame_good_i,
    input  logic       frame_bad_i,
    input  logic       frame_release_i,
    output logic       wr_bank_o,
    output logic       rd_bank_o,
    output logic       rd_valid_o,
    output logic       frame_ready_o,
    output logic [7:0] drop_count_o
);

    logic       full_q, full_d;
    logic       wr_bank_q, wr_bank_d;
    logic       rd_bank_q, rd_bank_d;
    logic       ready_q, ready_d;
    logic [7:0] drop_q, drop_d;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            full_q    <= 1'b0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            ready_q   <= 1'b0;
            drop_q    <= 8'd0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            ready_q   <= ready_d;
            drop_q    <= drop_d;
        end
    end

    always_comb begin
        full_d    = full_q & ~frame_release_i;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        ready_d   = 1'b0;
        drop_d    = drop_q;
        // Only one bank is ever full and it is never the write bank, so "other bank free" is !full.
        if (frame_good_i) begin
            if (!full_d) begin
                full_d    = 1'b1;
                ready_d   = 1'b1;
                rd_bank_d = wr_bank_q;
                wr_bank_d = ~wr_bank_q;
            end else begin
                drop_d = sat_inc8(drop_q);
            end
        end else if (frame_bad_i) begin
            drop_d = sat_inc8(drop_q);
        end
    end

    assign wr_bank_o     = wr_bank_q;
    assign rd_bank_o     = rd_bank_q;
    assign rd_valid_o    = full_q;
    assign frame_ready_o = ready_q;
    assign drop_count_o  = drop_q;

endmodule

// File: rtl/gray_frame_writer.sv
// Writes validated grayscale frames into a two-bank frame buffer and hands them to a consumer.
// A single pixel counter forms the in-bank address; the bank is the address MSB.
module gray_frame_writer
    import camera_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int ADDR_W = $clog2(2 * IMG_W * IMG_H)
) (
    input  logic                clk_in,
    input  logic                rst_n,
    gray_frame_writer_if.slave  bus
);

    localparam int                FRAME_PIX = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] FRAME_CNT = ADDR_W'(FRAME_PIX);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
    logic              overrun_q, overrun_d;
    logic              frame_error_q, frame_error_d;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [7:0]        wr_data_q;
    logic              pix_accept;
    logic              frame_good;
    logic              frame_bad;
    logic              wr_bank;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= SYNC;
            pix_cnt_q     <= '0;
            overrun_q     <= 1'b0;
            frame_error_q <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= 8'd0;
        end else begin
            state_q       <= state_d;
            pix_cnt_q     <= pix_cnt_d;
            overrun_q     <= overrun_d;
            frame_error_q <= frame_error_d;
            wr_en_q       <= pix_accept;
            if (pix_accept) begin
                wr_addr_q <= {wr_bank, pix_cnt_q[ADDR_W-2:0]};
                wr_data_q <= bus.gray;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        pix_cnt_d     = pix_cnt_q;
        overrun_d     = overrun_q;
        frame_error_d = frame_error_q;
        pix_accept    = 1'b0;
        frame_good    = 1'b0;
        frame_bad     = 1'b0;
        case (state_q)
            SYNC: begin
                if (bus.frame_done) begin
                    state_d   = CAPTURE;
                    pix_cnt_d = '0;
                    overrun_d = 1'b0;
                end
            end
            CAPTURE: begin
                if (bus.pixel_valid) begin
                    if (pix_cnt_q < FRAME_CNT) begin
                        pix_accept = 1'b1;
                        pix_cnt_d  = pix_cnt_q + 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
                // Judged on the counts including this cycle's pixel, then cleared for the next frame.
                if (bus.frame_done) begin
                    if (pix_cnt_d == FRAME_CNT && !overrun_d) begin
                        frame_good = 1'b1;
                    end else begin
                        frame_bad     = 1'b1;
                        frame_error_d = 1'b1;
                    end
                    pix_cnt_d = '0;
                    overrun_d = 1'b0;
                end
            end
            default: state_d = SYNC;
        endcase
    end

    frame_bank_ctrl u_bank_ctrl (
        .clk_in          (clk_in),
        .rst_n           (rst_n),
        .frame_good_i    (frame_good),
        .frame_bad_i     (frame_bad),
        .frame_release_i (bus.frame_release),
        .wr_bank_o       (wr_bank),
        .rd_bank_o       (bus.rd_bank),
        .rd_valid_o      (bus.rd_valid),
        .frame_ready_o   (bus.frame_ready),
        .drop_count_o    (bus.drop_count)
    );

    assign bus.wr_en       = wr_en_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.frame_error = frame_error_q;

endmodule
